spart_driver: RTL and testbench

Bus-master controller that sequences the SPART serial port. Programs the 16-bit baud divisor from a 2-bit switch setting after reset and whenever that setting changes. Then runs an echo loop: received bytes are pulled over the SPART I/O bus into a small FIFO and written back out through the transmitter. It sits beside the SPART at top level and owns the `iocs`, `iorw`, `ioaddr` and `databus` lines.

---
 rtl/spart_driver_if.sv | 13 +
 rtl/spart_driver.sv | 157 +++++++++++++++
 tb/tb_spart_driver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spart_driver_if.sv
// spart_driver_if: SPART I/O bus control and status lines between the driver (master) and the SPART (slave).
// Ports: iocs/iorw/ioaddr run master->slave; rda/tbr run slave->master.
// The 8-bit bidirectional databus stays a plain inout pin on the driver so tristate resolution stays at module level.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from br_cfg, then echoes received bytes back out via a small FIFO.
// Ports: clk/rst (async active-high), br_cfg (async switches), bus (iocs/iorw/ioaddr/rda/tbr), databus (tristate),
//        cfg_done (echo loop running), fifo_count (echo FIFO occupancy). Bus outputs are registered, 1-cycle accesses.
module spart_driver #(
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int GAP_CYCLES = 2    // >= 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      br_cfg,
  spart_driver_if.master                  bus,
  inout  wire  [7:0]                      databus,
  output logic                            cfg_done,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CFG_LO, CFG_HI, GAP, RUN, RD, WR} state_t;

  // Divisor value (N-1) for 100 MHz with 16x oversampling; hi selects the upper byte.
  function automatic logic [7:0] div_byte(input logic [1:0] sel, input logic hi);
    logic [15:0] d;
    case (sel)
      2'b00:   d = 16'd1301;
      2'b01:   d = 16'd650;
      2'b10:   d = 16'd325;
      default: d = 16'd162;
    endcase
    return hi ? d[15:8] : d[7:0];
  endfunction

  logic [1:0]    sync1_q, sync2_q, cfg_l_q;
  logic [1:0]    cfg_s;
  state_t        state_q, state_d, ret_q, ret_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          iocs_q, iocs_d, iorw_q, iorw_d, cfg_done_q, cfg_done_d;
  logic [1:0]    ioaddr_q, ioaddr_d;
  logic [7:0]    dout_q, dout_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_empty, fifo_full, push, pop;

  assign cfg_s      = sync2_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  // The bus access ends at the edge that closes the RD/WR cycle.
  assign push       = (state_q == RD);
  assign pop        = (state_q == WR);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE:   state_d = CFG_LO;
      CFG_LO: begin state_d = GAP; ret_d = CFG_HI; gap_d = '0; end
      CFG_HI: begin state_d = GAP; ret_d = RUN;    gap_d = '0; end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = ret_q;
        else                   gap_d   = gap_q + 1'b1;
      end
      RUN: begin
        // Reprogramming waits for an empty FIFO and an idle transmitter so no echo byte is sent at a stale baud rate.
        if (cfg_s != cfg_l_q && fifo_empty && bus.tbr) state_d = CFG_LO;
        else if (bus.rda && !fifo_full)                 state_d = RD;
        else if (bus.tbr && !fifo_empty)                state_d = WR;
      end
      RD, WR: begin state_d = GAP; ret_d = RUN; gap_d = '0; end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the flops line up with the state they describe.
  always_comb begin
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = 2'b00;
    dout_d     = 8'h00;
    cfg_done_d = cfg_done_q;
    case (state_d)
      CFG_LO: begin
        iocs_d = 1'b1; iorw_d = 1'b0; ioaddr_d = 2'b10;
        // cfg_l is being loaded from cfg_s on this same edge, so use cfg_s directly.
        dout_d = div_byte(cfg_s, 1'b0);
        cfg_done_d = 1'b0;
      end
      CFG_HI: begin
        iocs_d = 1'b1; iorw_d = 1'b0; ioaddr_d = 2'b11;
        dout_d = div_byte(cfg_l_q, 1'b1);
      end
      RD: iocs_d = 1'b1;
      WR: begin
        iocs_d = 1'b1; iorw_d = 1'b0;
        dout_d = mem_q[rd_ptr_q];
      end
      RUN:     cfg_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      cfg_l_q    <= 2'b00;
      state_q    <= IDLE;
      ret_q      <= IDLE;
      gap_q      <= '0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= 2'b00;
      dout_q     <= 8'h00;
      cfg_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync1_q    <= br_cfg;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      ret_q      <= ret_d;
      gap_q      <= gap_d;
      if (state_d == CFG_LO) cfg_l_q <= cfg_s;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      dout_q     <= dout_d;
      cfg_done_q <= cfg_done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_q + 1'b1;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q  <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= databus;
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = ioaddr_q;
  assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
  assign cfg_done   = cfg_done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_spart_driver.sv
module tb_spart_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       cfg_done;
  logic [2:0] fifo_count;
  wire  [7:0] databus;
  logic [7:0] spart_drv = 8'h00;

  int total = 0;
  int bad   = 0;
  int rd_count = 0;

  logic [9:0] exp_q [$];   // expected bus writes {ioaddr, data}
  logic [7:0] rx_q  [$];   // bytes the SPART model holds for the driver

  spart_driver_if bus();

  spart_driver #(.FIFO_DEPTH(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .bus(bus.master),
    .databus(databus), .cfg_done(cfg_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  assign databus = (bus.iocs && bus.iorw) ? spart_drv : 8'hzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPART model: presents the head byte during a read cycle and raises rda while bytes are pending.
  always @(negedge clk) begin
    if (!rst && bus.iocs && bus.iorw) begin
      rd_count++;
      if (rx_q.size() != 0) spart_drv = rx_q.pop_front();
      else check("read_with_rda_low", 32'd0, 32'd1);
    end
    bus.rda = (rx_q.size() != 0);
  end

  // Write monitor: every write on the bus must match the scoreboard head.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && bus.iocs) begin
      check("ioaddr_not_01", {31'd0, bus.ioaddr == 2'b01}, 32'd0);
      if (!bus.iorw) begin
        if (exp_q.size() == 0) check("write_expected", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          check("bus_write", {22'd0, bus.ioaddr, databus}, {22'd0, e});
          if (bus.ioaddr[1]) check("cfg_done_low_in_cfg", {31'd0, cfg_done}, 32'd0);
        end
      end
    end
  end

  task automatic wait_exp_empty(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic wait_fifo(input string tag, input int target);
    int n = 0;
    while (fifo_count != 3'(target) && n < 100) begin @(negedge clk); n++; end
    check(tag, {29'd0, fifo_count}, target);
  endtask

  task automatic wait_cfg_done(input string tag);
    int n = 0;
    while (cfg_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check(tag, {31'd0, cfg_done}, 32'd1);
  endtask

  initial begin
    int n;
    int rd_base;
    bus.tbr = 1'b0;
    // Synchronizer resets to 00, so the first pass programs 1301 (0x0515); the 01 setting is applied once tbr=1.
    exp_q.push_back({2'b10, 8'h15});
    exp_q.push_back({2'b11, 8'h05});
    repeat (3) @(negedge clk);
    check("rst_iocs", {31'd0, bus.iocs}, 32'd0);
    check("rst_iorw", {31'd0, bus.iorw}, 32'd1);
    check("rst_ioaddr", {30'd0, bus.ioaddr}, 32'd0);
    check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);

    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_iocs", {31'd0, bus.iocs}, 32'd0);
    n = 0;
    while (n < 40) begin
      @(posedge clk); n++; #1;
      if (n == 1) check("first_cfg_lo", {30'd0, bus.iocs, bus.iorw, bus.ioaddr}, 32'b1010);
      if (cfg_done) break;
    end
    check("cfg_done_latency", n, 32'd7);

    // Pending 01 setting is programmed once the transmitter is ready.
    exp_q.push_back({2'b10, 8'h8A});
    exp_q.push_back({2'b11, 8'h02});
    bus.tbr = 1'b1;
    wait_exp_empty("reprog_01_done");
    wait_cfg_done("cfg_done_after_01");

    // Single echo: 41 read, then written back.
    rx_q.push_back(8'h41); exp_q.push_back({2'b00, 8'h41});
    wait_fifo("echo_fifo_1", 1);
    wait_fifo("echo_fifo_0", 0);
    wait_exp_empty("echo_41");

    // Fill the FIFO with tbr low: only 4 of 5 bytes may be read.
    bus.tbr = 1'b0;
    rd_base = rd_count;
    for (int i = 1; i <= 5; i++) begin
      rx_q.push_back(8'(i)); exp_q.push_back({2'b00, 8'(i)});
    end
    repeat (40) @(negedge clk);
    check("full_reads", rd_count - rd_base, 32'd4);
    check("full_count", {29'd0, fifo_count}, 32'd4);
    check("full_held_byte", rx_q.size(), 32'd1);
    bus.tbr = 1'b1;
    wait_exp_empty("drain_order");
    repeat (3) @(negedge clk);
    check("drain_count", {29'd0, fifo_count}, 32'd0);

    // Reconfigure 01->11 with two bytes queued: echoes go out first.
    bus.tbr = 1'b0;
    rx_q.push_back(8'hAA); exp_q.push_back({2'b00, 8'hAA});
    rx_q.push_back(8'hBB); exp_q.push_back({2'b00, 8'hBB});
    wait_fifo("reconf_queued", 2);
    br_cfg = 2'b11;
    exp_q.push_back({2'b10, 8'hA2});
    exp_q.push_back({2'b11, 8'h00});
    repeat (10) @(negedge clk);
    check("reconf_deferred", {31'd0, cfg_done}, 32'd1);
    bus.tbr = 1'b1;
    wait_exp_empty("reconf_writes");
    wait_cfg_done("reconf_cfg_done");

    // rda and tbr together with the FIFO partly full: read wins.
    bus.tbr = 1'b0;
    rx_q.push_back(8'h11); exp_q.push_back({2'b00, 8'h11});
    wait_fifo("prio_fifo_1", 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rx_q.push_back(8'h22); exp_q.push_back({2'b00, 8'h22});
    @(negedge clk); #1 bus.tbr = 1'b1;
    n = 0;
    while (n < 10) begin @(posedge clk); n++; #1; if (bus.iocs) break; end
    check("prio_access_seen", {31'd0, bus.iocs}, 32'd1);
    check("prio_rd_first", {31'd0, bus.iorw}, 32'd1);
    wait_exp_empty("prio_writes");

    // Reset in the middle of a WR cycle.
    bus.tbr = 1'b0;
    rx_q.push_back(8'h5A);
    wait_fifo("rstwr_fifo_1", 1);
    @(negedge clk); bus.tbr = 1'b1;
    n = 0;
    while (n < 20) begin @(posedge clk); n++; #1; if (bus.iocs && !bus.iorw) break; end
    check("rstwr_in_wr", {31'd0, bus.iocs && !bus.iorw}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstwr_iocs_async", {31'd0, bus.iocs}, 32'd0);
    check("rstwr_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rstwr_cfg_done", {31'd0, cfg_done}, 32'd0);
    exp_q.push_back({2'b10, 8'h15});
    exp_q.push_back({2'b11, 8'h05});
    exp_q.push_back({2'b10, 8'hA2});
    exp_q.push_back({2'b11, 8'h00});
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_exp_empty("rstwr_reprog");
    wait_cfg_done("rstwr_cfg_done_back");
    repeat (5) @(negedge clk);
    check("final_rx_empty", rx_q.size(), 32'd0);
    check("final_exp_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
